uart_rx_param: RTL
==================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 SHALL have parameter PARITY, default 0, 0=none, 1=odd, 2=even.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1..2.
REQ-004 SHALL have parameter DIV_W, default 16, width of the divisor input.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_div  input  DIV_W  oversample tick period minus 1 (tick every i_div+1 clk).
REQ-008 i_rx  input  1  asynchronous serial line, idle high.
REQ-009 i_ready  input  1  consumer accepts o_data when high with o_valid.
REQ-010 o_data  output  DATA_BITS  received word, bit 0 = first data bit on line.
REQ-011 o_valid  output  1  o_data and flags hold an unaccepted word.
REQ-012 o_parity_err  output  1  parity mismatch for the word on o_data.
REQ-013 o_frame_err  output  1  a stop bit sampled low for the word on o_data.
REQ-014 o_overrun  output  1  sticky: a completed frame was dropped.
REQ-015 o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 i_rx SHALL pass a 2-FF synchronizer (reset value 1); all logic uses the synchronized signal rxs.
REQ-017 FSM states SHALL be IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-018 IDLE: a 1->0 transition on rxs SHALL enter START, latch i_div, clear tick and sample counters on that same edge.
REQ-019 Tick generator SHALL run only outside IDLE/WAIT_HI; i_div changes mid-frame SHALL have no effect.
REQ-020 Each bit SHALL span 16 ticks; ticks numbered 0..15 from bit start.
REQ-021 Bit value SHALL be majority (>=2 of 3) of rxs at ticks 7, 8, 9.
REQ-022 START: majority 1 SHALL return to IDLE (false start), no output, no flag change.
REQ-023 DATA: DATA_BITS bits SHALL be shifted in LSB first, then PAR if PARITY!=0, else STOP.
REQ-024 PAR: error SHALL be set when XOR(data, parity bit) is 0 for odd, 1 for even.
REQ-025 STOP: each of STOP_BITS bits sampled low SHALL set frame error.
REQ-026 Frame completes at tick 9 of the last stop bit; next state IDLE if no frame error, else WAIT_HI.
REQ-027 WAIT_HI SHALL ignore rxs until rxs=1 for one clk, then enter IDLE (break handling).
REQ-028 On completion, o_data and both error flags SHALL load and o_valid rise 1 clk after the completion tick.
REQ-029 o_valid SHALL stay high, o_data/flags stable, until o_valid && i_ready; then o_valid falls next clk.
REQ-030 Completion while o_valid=1 and i_ready=0: new frame discarded, o_data unchanged, o_overrun set.
REQ-031 Completion coinciding with accept (o_valid && i_ready): new word loads, o_valid stays 1, no overrun.
REQ-032 o_overrun SHALL clear only on the clk after an accept handshake in which no new drop occurs.
REQ-033 Frames with errors SHALL still be delivered with their flags.

Reset
REQ-034 rst_n low SHALL immediately force: state IDLE, counters 0, synchronizer 1, o_data 0, o_valid 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_busy 0.
REQ-035 Reset mid-frame SHALL abandon the frame; after release a new start edge is required.

Verification (DATA_BITS=8, PARITY=2, STOP_BITS=1, i_div=3: bit = 64 clk; i_ready=1 unless stated)
REQ-036 Send 0xA5, parity 0, stop 1 -> o_valid 1 clk after stop tick 9, o_data=0xA5, both error flags 0.
REQ-037 rxs low for 20 clk then high -> o_busy pulses, returns IDLE, o_valid never asserts.
REQ-038 Send 0x3C with parity bit 1 -> o_data=0x3C, o_parity_err=1, o_frame_err=0.
REQ-039 Hold i_rx low 15 bit times then high -> o_data=0x00, o_frame_err=1, state WAIT_HI until line high, next frame 0x55 received clean.
REQ-040 i_ready=0, send 0x11 then 0x22 -> o_data=0x11, o_overrun=1; assert i_ready -> o_valid drops, o_overrun clears.
REQ-041 Assert rst_n low during bit 4 of a frame -> all outputs 0 immediately; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable word length, parity and stop bits.
// Each bit spans 16 ticks; the bit value is the majority vote of ticks 7, 8 and 9.
module uart_rx_param #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_W-1:0]     i_div,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rxs_q, rxs_prev_q;
    logic [DIV_W-1:0]     div_q, div_d, div_cnt_q, div_cnt_d;
    logic [3:0]           tick_cnt_q, tick_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 s7_q, s7_d, s8_q, s8_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 pbit_q, pbit_d;
    logic                 ferr_q, ferr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 ovr_q, ovr_d;

    logic tick, mid, bit_end, maj, complete, frame_ferr, perr_calc, accept;

    assign tick    = (div_cnt_q == div_q);
    assign mid     = tick && (tick_cnt_q == 4'd9);
    assign bit_end = tick && (tick_cnt_q == 4'd15);
    assign maj     = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    assign accept  = valid_q & i_ready;

    assign perr_calc = (PARITY == 1) ? ~(^shift_q ^ pbit_q) :
                       (PARITY == 2) ?  (^shift_q ^ pbit_q) : 1'b0;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        s7_d       = s7_q;
        s8_d       = s8_q;
        shift_d    = shift_q;
        pbit_d     = pbit_q;
        ferr_d     = ferr_q;
        complete   = 1'b0;
        frame_ferr = ferr_q;

        // The tick generator only runs while a frame is being sampled.
        if (state_q == START || state_q == DATA || state_q == PAR || state_q == STOP) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
                if (tick_cnt_q == 4'd7) s7_d = rxs_q;
                if (tick_cnt_q == 4'd8) s8_d = rxs_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (rxs_prev_q && !rxs_q) begin
                    state_d    = START;
                    div_d      = i_div;
                    div_cnt_d  = '0;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    ferr_d     = 1'b0;
                end
            end
            START: begin
                if (mid && maj) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (mid) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            PAR: begin
                if (mid) pbit_d = maj;
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (mid) begin
                    frame_ferr = ferr_q | ~maj;
                    ferr_d     = frame_ferr;
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        complete = 1'b1;
                        state_d  = frame_ferr ? WAIT_HI : IDLE;
                    end
                end else if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WAIT_HI: begin
                if (rxs_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        ovr_d      = ovr_q;
        if (complete && (!valid_q || accept)) begin
            data_d     = shift_q;
            perr_out_d = perr_calc;
            ferr_out_d = frame_ferr;
            valid_d    = 1'b1;
            if (accept) ovr_d = 1'b0;
        end else if (complete) begin
            // Consumer still holds the previous word: drop the new one.
            ovr_d = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            state_q    <= IDLE;
            div_q      <= '0;
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            shift_q    <= '0;
            pbit_q     <= 1'b0;
            ferr_q     <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= i_rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            state_q    <= state_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            s7_q       <= s7_d;
            s8_q       <= s8_d;
            shift_q    <= shift_d;
            pbit_q     <= pbit_d;
            ferr_q     <= ferr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_out_q;
    assign o_frame_err  = ferr_out_q;
    assign o_overrun    = ovr_q;
    assign o_busy       = (state_q != IDLE);

endmodule
